// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding bus access with lane steering,
// load extension, alignment checking and a bus timeout.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic [1:0]            MemSizeM_i,
    input  logic                  MemUnsignedM_i,
    output logic                  MemReq_o,
    output logic                  MemWe_o,
    output logic [DATA_WIDTH-1:0] MemAddr_o,
    output logic [DATA_WIDTH-1:0] MemWData_o,
    output logic [3:0]            MemByteEn_o,
    input  logic [DATA_WIDTH-1:0] MemRData_i,
    input  logic                  MemAck_i,
    output logic [DATA_WIDTH-1:0] ReadDataM_o,
    output logic                  DoneM_o,
    output logic                  FaultM_o,
    output logic                  StallM_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       addr_lo_p1;
    logic [1:0]       size_p1;
    logic             uns_p1;

    logic req_any;
    logic illegal;
    logic misaligned;

    function automatic logic [DATA_WIDTH-1:0] replicate_store(
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            size
    );
        case (size)
            2'b00:   return {(DATA_WIDTH/8){data[7:0]}};
            2'b01:   return {(DATA_WIDTH/16){data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(
        input logic [1:0] size,
        input logic [1:0] off,
        input logic       we
    );
        if (!we)
            return 4'b1111;
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic        [DATA_WIDTH-1:0] sh;
        logic signed [7:0]            b;
        logic signed [15:0]           h;
        logic signed [DATA_WIDTH-1:0] ext;
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            2'b00: begin
                if (uns) ext = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
                else     ext = b;
            end
            2'b01: begin
                if (uns) ext = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
                else     ext = h;
            end
            default: ext = sh;
        endcase
        return ext;
    endfunction

    assign req_any    = MemReadM_i | MemWriteM_i;
    assign illegal    = (MemReadM_i & MemWriteM_i) | (MemSizeM_i == 2'b11);
    assign misaligned = ((MemSizeM_i == 2'b01) & ALUResultM_i[0]) |
                        ((MemSizeM_i == 2'b10) & (ALUResultM_i[1:0] != 2'b00));

    assign StallM_o = (state == BUSY) | ((state == IDLE) & req_any);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            addr_lo_p1  <= '0;
            size_p1     <= '0;
            uns_p1      <= 1'b0;
            MemReq_o    <= 1'b0;
            MemWe_o     <= 1'b0;
            MemAddr_o   <= '0;
            MemWData_o  <= '0;
            MemByteEn_o <= '0;
            ReadDataM_o <= '0;
            DoneM_o     <= 1'b0;
            FaultM_o    <= 1'b0;
        end else begin
            DoneM_o  <= 1'b0;
            FaultM_o <= 1'b0;
            case (state)
                // Accept: latch the access, or fault without touching the bus
                IDLE: begin
                    if (req_any) begin
                        if (illegal || misaligned) begin
                            state    <= RESP;
                            DoneM_o  <= 1'b1;
                            FaultM_o <= 1'b1;
                        end else begin
                            state       <= BUSY;
                            wait_cnt    <= '0;
                            addr_lo_p1  <= ALUResultM_i[1:0];
                            size_p1     <= MemSizeM_i;
                            uns_p1      <= MemUnsignedM_i;
                            MemReq_o    <= 1'b1;
                            MemWe_o     <= MemWriteM_i;
                            MemAddr_o   <= {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};
                            MemWData_o  <= replicate_store(WriteDataM_i, MemSizeM_i);
                            MemByteEn_o <= byte_enable(MemSizeM_i, ALUResultM_i[1:0],
                                                       MemWriteM_i);
                        end
                    end
                end
                // Bus phase: MemWe_o doubles as the latched write flag
                BUSY: begin
                    if (MemAck_i) begin
                        state    <= RESP;
                        MemReq_o <= 1'b0;
                        MemWe_o  <= 1'b0;
                        DoneM_o  <= 1'b1;
                        if (!MemWe_o)
                            ReadDataM_o <= extend_load(MemRData_i, addr_lo_p1,
                                                       size_p1, uns_p1);
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= RESP;
                        MemReq_o    <= 1'b0;
                        MemWe_o     <= 1'b0;
                        DoneM_o     <= 1'b1;
                        FaultM_o    <= 1'b1;
                        ReadDataM_o <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues accesses and plays the bus,
// a negedge monitor checks bus fields and responses against queued expectations.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] ALUResultM_i = '0;
    logic [31:0] WriteDataM_i = '0;
    logic        MemReadM_i = 1'b0;
    logic        MemWriteM_i = 1'b0;
    logic [1:0]  MemSizeM_i = '0;
    logic        MemUnsignedM_i = 1'b0;
    logic        MemReq_o;
    logic        MemWe_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWData_o;
    logic [3:0]  MemByteEn_o;
    logic [31:0] MemRData_i = '0;
    logic        MemAck_i = 1'b0;
    logic [31:0] ReadDataM_o;
    logic        DoneM_o;
    logic        FaultM_o;
    logic        StallM_o;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
        .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i),
        .MemSizeM_i(MemSizeM_i), .MemUnsignedM_i(MemUnsignedM_i),
        .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o),
        .MemWData_o(MemWData_o), .MemByteEn_o(MemByteEn_o),
        .MemRData_i(MemRData_i), .MemAck_i(MemAck_i),
        .ReadDataM_o(ReadDataM_o), .DoneM_o(DoneM_o), .FaultM_o(FaultM_o),
        .StallM_o(StallM_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          done_cyc;
        int          req_cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] rd_model = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference load result from plain arithmetic on the bus word.
    function automatic logic [31:0] load_value(input logic [31:0] rdata, input int off,
                                               input int size, input logic uns);
        longint unsigned v;
        v = longint'(rdata) >> (8 * off);
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
            v = v % 64'h1_0000_0000;
        end
        return v[31:0];
    endfunction

    // Issue one access from IDLE (called at posedge+1) and act as the bus.
    // d = number of BUSY cycles before ack (d >= TO means no ack).
    task automatic access(input logic rd, input logic wr, input int size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int d);
        exp_t e;
        logic flt;
        int   off, busy;
        off = addr % 4;
        flt = (rd && wr) || size == 3 || (size == 1 && off % 2 != 0) ||
              (size == 2 && off != 0);
        e.fault = flt || d >= TO;
        e.we    = wr;
        e.addr  = addr - off;
        if (size == 0)      e.wdata = (wdata % 256) * 32'h0101_0101;
        else if (size == 1) e.wdata = (wdata % 65536) * 32'h0001_0001;
        else                e.wdata = wdata;
        if (!wr)            e.be = 4'hF;
        else if (size == 0) e.be = 4'(1 << off);
        else if (size == 1) e.be = 4'(3 << off);
        else                e.be = 4'hF;
        if (!flt && d >= TO) rd_model = 32'h0;
        else if (!flt && !wr) rd_model = load_value(rdata, off, size, uns);
        e.rdata      = rd_model;
        e.done_cyc   = cyc + (flt ? 1 : (d < TO ? d + 2 : TO + 1));
        e.req_cycles = flt ? 0 : (d < TO ? d + 1 : TO);
        exp_q.push_back(e);

        MemReadM_i = rd; MemWriteM_i = wr; MemSizeM_i = 2'(size);
        MemUnsignedM_i = uns; ALUResultM_i = addr; WriteDataM_i = wdata;
        @(negedge clk_i); check("stall_accept", 32'(StallM_o), 32'h1);
        @(posedge clk_i); #1;
        MemReadM_i = 1'b0; MemWriteM_i = 1'b0; ALUResultM_i = $urandom;
        WriteDataM_i = $urandom;
        if (!flt) begin
            busy = (d < TO) ? d + 1 : TO;
            for (int c = 0; c < busy; c++) begin
                MemAck_i   = (c == d);
                MemRData_i = (c == d) ? rdata : $urandom;
                @(negedge clk_i); check("stall_busy", 32'(StallM_o), 32'h1);
                @(posedge clk_i); #1;
            end
        end
        // RESP: anything presented now must be ignored
        MemAck_i = 1'($urandom); MemRData_i = $urandom; MemReadM_i = 1'($urandom);
        @(negedge clk_i); check("stall_resp", 32'(StallM_o), 32'h0);
        @(posedge clk_i); #1;
        MemAck_i = 1'b0; MemReadM_i = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            MemAck_i = 1'($urandom); MemRData_i = $urandom;
            @(negedge clk_i);
            check("stall_idle", 32'(StallM_o), 32'h0);
            check("rdata_hold_idle", ReadDataM_o, rd_model);
            @(posedge clk_i); #1;
            MemAck_i = 1'b0;
        end
    endtask

    // Monitor: bus fields at the first request cycle, responses at DoneM_o.
    int   req_cnt = 0;
    logic req_prev = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            req_cnt  = 0;
            req_prev = 1'b0;
        end else begin
            if (MemReq_o) begin
                req_cnt++;
                if (!req_prev) begin
                    if (exp_q.size() == 0) begin
                        check("bus_unexpected_req", 32'h1, 32'h0);
                    end else begin
                        check("bus_addr", MemAddr_o, exp_q[0].addr);
                        check("bus_we", 32'(MemWe_o), 32'(exp_q[0].we));
                        check("bus_be", 32'(MemByteEn_o), 32'(exp_q[0].be));
                        if (exp_q[0].we) check("bus_wdata", MemWData_o, exp_q[0].wdata);
                    end
                end
            end
            req_prev = MemReq_o;
            if (DoneM_o) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_fault", 32'(FaultM_o), 32'(e.fault));
                    check("resp_rdata", ReadDataM_o, e.rdata);
                    check("resp_latency", 32'(cyc), 32'(e.done_cyc));
                    check("resp_req_cycles", 32'(req_cnt), 32'(e.req_cycles));
                end
                req_cnt = 0;
            end else if (FaultM_o) begin
                check("fault_without_done", 32'h1, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, size, d, off;
        logic [31:0] addr;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", 32'(MemReq_o), 32'h0);
        check("rst_we", 32'(MemWe_o), 32'h0);
        check("rst_done", 32'(DoneM_o), 32'h0);
        check("rst_fault", 32'(FaultM_o), 32'h0);
        check("rst_rdata", ReadDataM_o, 32'h0);
        check("rst_addr", MemAddr_o, 32'h0);
        check("rst_wdata", MemWData_o, 32'h0);
        check("rst_be", 32'(MemByteEn_o), 32'h0);
        check("rst_stall", 32'(StallM_o), 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        access(1, 0, 0, 0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1);    // LB sign-extend
        idle_gap(1);
        access(0, 1, 1, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0);    // SH zero-wait
        idle_gap(1);
        access(1, 0, 2, 0, 32'h0000_3001, 32'h0, 32'h0, 0);            // LW misaligned
        access(1, 0, 1, 1, 32'h0000_0002, 32'h0, 32'h0, TO + 5);       // LHU timeout
        access(1, 1, 2, 0, 32'h0000_0010, 32'h5555_5555, 32'h0, 0);    // read and write
        access(1, 0, 3, 0, 32'h0000_0020, 32'h0, 32'h0, 0);            // size 11
        access(1, 0, 2, 0, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, TO - 1); // ack on last cycle
        access(1, 0, 1, 0, 32'h0000_0046, 32'h0, 32'h8001_7FFF, 2);    // LH upper half
        access(0, 1, 0, 0, 32'h0000_0051, 32'h0000_00A5, 32'h0, 3);    // SB lane 1
        idle_gap(2);

        for (int n = 0; n < 70; n++) begin
            op   = $urandom_range(0, 9);
            size = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                off  = addr % 4;
                if (size == 1) addr = addr - (off % 2);
                if (size == 2) addr = addr - off;
            end
            d = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 4) : $urandom_range(0, 4);
            access(op == 0 || op > 5, op <= 5, size, 1'($urandom), addr, $urandom, $urandom, d);
            idle_gap($urandom_range(0, 2));
        end

        // Reset in the middle of a bus access
        MemReadM_i = 1'b1; MemSizeM_i = 2'b10; ALUResultM_i = 32'h0000_0040;
        exp_q.push_back('{fault: 1'b0, rdata: 32'h0, we: 1'b0, addr: 32'h0000_0040,
                          wdata: 32'h0, be: 4'hF, done_cyc: 0, req_cycles: 0});
        @(posedge clk_i); #1;
        MemReadM_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check("midrst_req", 32'(MemReq_o), 32'h0);
        check("midrst_we", 32'(MemWe_o), 32'h0);
        check("midrst_rdata", ReadDataM_o, 32'h0);
        check("midrst_addr", MemAddr_o, 32'h0);
        check("midrst_be", 32'(MemByteEn_o), 32'h0);
        check("midrst_stall", 32'(StallM_o), 32'h0);
        rd_model = 32'h0;
        @(negedge clk_i);
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0; MemAck_i = 1'b1; MemRData_i = 32'h1234_5678;
        @(posedge clk_i); #1;
        MemAck_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("late_ack_no_done", 32'(DoneM_o), 32'h0);
            check("late_ack_no_req", 32'(MemReq_o), 32'h0);
        end
        check("late_ack_rdata", ReadDataM_o, 32'h0);
        @(posedge clk_i); #1;
        access(1, 0, 0, 1, 32'h0000_0063, 32'h0, 32'h80AA_BBCC, 0);    // LBU after reset
        idle_gap(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
